serial_addsub_ctrl: RTL
=======================

Name: serial_addsub_ctrl

Overview:
- Bit-serial sequencer for the team's 1-bit adder/subtractor cell.
- Accepts two WIDTH-bit operands and a mode, then drives the cell LSB-first for WIDTH cycles.
- Feeds the registered carry/borrow (Ts) back into the cell's Te, and assembles the WIDTH-bit result with carry/borrow and signed overflow.
- Sits directly upstream/downstream of the cell: it produces M/A/B/Te and consumes S/Ts.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE
op_sub  input  1  0 = add (A+B), 1 = subtract (A-B); latched on accepted start
a_in  input  WIDTH  operand A; latched on accepted start
b_in  input  WIDTH  operand B; latched on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when result is valid
result  output  WIDTH  sum/difference; held until next accepted start
carry_out  output  1  final Ts: carry (add) or borrow (sub)
overflow  output  1  two's-complement signed overflow
err  output  1  sticky self-check mismatch (see Optional Feature)
cell_m  output  1  mode to cell (latched op_sub)
cell_a  output  1  current A bit to cell
cell_b  output  1  current B bit to cell
cell_te  output  1  carry/borrow-in to cell
cell_s  input  1  cell sum/difference bit (combinational)
cell_ts  input  1  cell carry/borrow-out (combinational)

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous, active-low.
- Reset (async, any state): state=IDLE; busy, done, result, carry_out, overflow, err, the carry register, the bit counter and the shift registers all go to 0. cell_m/a/b/te=0.
- States: IDLE, RUN, DONE.
- IDLE: on start=1 at an edge, latch a_in/b_in into shift registers, latch op_sub, clear carry register (Te=0 for both modes), counter=0, go to RUN. Otherwise stay.
- RUN, combinational cell drive: cell_a=a_sh[0], cell_b=b_sh[0], cell_te=carry_reg, cell_m=op latch.
- RUN, per edge: shift cell_s into result register from the MSB side (right shift); carry_reg<=cell_ts; shift a_sh and b_sh right; counter++. start is ignored in RUN.
- RUN exit: after the edge that processes bit WIDTH-1, go to DONE.
- Outputs on the DONE transition: result, carry_out=cell_ts of the last bit, and overflow become visible; done=1 for exactly one cycle.
- Overflow rule: a_msb and b_msb are the latched operand MSBs, r_msb the result MSB.
  - add: (a_msb==b_msb) && (r_msb!=a_msb)
  - sub: (a_msb!=b_msb) && (r_msb!=a_msb)
- Latency: done rises WIDTH+1 edges after the edge that accepts start (1 load edge + WIDTH bit edges). busy is high for exactly WIDTH cycles.
- DONE: next edge goes to IDLE. If start=1 in DONE, it is accepted exactly as in IDLE and the block goes straight to RUN (back-to-back operation, no bubble).
- Hold and readback: result, carry_out and overflow hold their values until the next accepted start. They are not cleared in IDLE.
- Internal result register: updates during RUN. The result port shows the final value only from DONE onward; intermediate shifting is not exposed.
- cell_* in IDLE/DONE: cell_a=cell_b=cell_te=0; cell_m holds the last latched op.
- Input changes: a_in, b_in and op_sub changing during RUN have no effect.

Optional Feature:
- Macro: SERIAL_ADDSUB_CHECK_EN.
- Defined:
  - On accepted start, an internal golden model computes a_in±b_in at WIDTH+1 bits.
  - At DONE, {carry_out,result} is compared against it; for sub, carry_out is compared with the borrow bit (a<b unsigned).
  - Any mismatch sets err=1 (sticky until reset).
- Not defined: err tied to 0 and no checker logic is synthesized.

Test Plan:
- Add, WIDTH=8, 0x35+0x4A: start 1 cycle -> busy 8 cycles, done at edge 9, result=0x7F, carry_out=0, overflow=0.
- Add 0xFF+0x01 -> result=0x00, carry_out=1, overflow=0. Add 0x7F+0x01 -> result=0x80, carry_out=0, overflow=1.
- Sub 0x05-0x07 -> result=0xFE, carry_out(borrow)=1, overflow=0. Sub 0x80-0x01 -> result=0x7F, borrow=0, overflow=1.
- Start mid-RUN and back-to-back:
  - Begin 0x10+0x20; assert start with 0xAA-0x55 during RUN -> ignored, result=0x30.
  - Assert start with 0xAA-0x55 in the DONE cycle -> accepted; result=0x55, borrow=0, overflow=1 after a further 9 edges.
- Reset mid-op: rst_n low after 4 bit edges -> busy, done, result and carry_out are 0 immediately (asynchronously). A following 0x01+0x01 gives result=0x02.
- With SERIAL_ADDSUB_CHECK_EN, an exhaustive 8-bit add/sub sweep -> err stays 0. With the cell's cell_ts forced to 0 -> err=1 after the first carry-producing op.

Source files
------------

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial sequencer for the 1-bit adder/subtractor cell: drives the cell LSB-first and
// assembles result, carry/borrow and overflow. Optional checker: SERIAL_ADDSUB_CHECK_EN.
module serial_addsub_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             err,
    output logic             cell_m,
    output logic             cell_a,
    output logic             cell_b,
    output logic             cell_te,
    input  logic             cell_s,
    input  logic             cell_ts
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_sh_q, b_sh_q;
    logic [WIDTH-2:0] res_sh_q;
    logic [CntW-1:0]  cnt_q;
    logic             carry_q;
    logic             op_q;
    logic             a_msb_q, b_msb_q;
    logic             busy_q, done_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_out_q, overflow_q;

    logic             accept;
    logic             last_bit;
    logic             in_run;
    logic [WIDTH-1:0] res_d;
    logic             overflow_d;

    assign in_run   = (state_q == StRun);
    assign accept   = start && !in_run;
    assign last_bit = (cnt_q == CntW'(WIDTH - 1));
    // The final bit arrives straight from the cell, so the full result is the shift reg plus cell_s.
    assign res_d    = {cell_s, res_sh_q};

    always_comb begin
        overflow_d = 1'b0;
        if (op_q) begin
            overflow_d = (a_msb_q != b_msb_q) && (cell_s != a_msb_q);
        end else begin
            overflow_d = (a_msb_q == b_msb_q) && (cell_s != a_msb_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            res_sh_q    <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            op_q        <= 1'b0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (accept) begin
                        a_sh_q  <= a_in;
                        b_sh_q  <= b_in;
                        a_msb_q <= a_in[WIDTH-1];
                        b_msb_q <= b_in[WIDTH-1];
                        op_q    <= op_sub;
                        carry_q <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    res_sh_q <= res_d[WIDTH-1:1];
                    carry_q  <= cell_ts;
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    cnt_q    <= cnt_q + CntW'(1);
                    if (last_bit) begin
                        result_q    <= res_d;
                        carry_out_q <= cell_ts;
                        overflow_q  <= overflow_d;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

    assign cell_m  = op_q;
    assign cell_a  = in_run ? a_sh_q[0] : 1'b0;
    assign cell_b  = in_run ? b_sh_q[0] : 1'b0;
    assign cell_te = in_run ? carry_q : 1'b0;

`ifdef SERIAL_ADDSUB_CHECK_EN
    logic [WIDTH:0] gold_q;
    logic           err_q;

    // For subtraction, bit WIDTH of the zero-extended difference is exactly the borrow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gold_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (accept) begin
                gold_q <= op_sub ? ({1'b0, a_in} - {1'b0, b_in}) : ({1'b0, a_in} + {1'b0, b_in});
            end
            if (state_q == StDone && {carry_out_q, result_q} != gold_q) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
